// File: rtl/motor_pkg.sv
// Shared types and helpers for the H-bridge ramp driver: channel state encoding,
// bridge pin codes and the PWM period calculation.
package motor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DECEL = 2'd2,
        ST_DEAD  = 2'd3
    } ch_state_t;

    // {IN1, IN2} codes driven onto each bridge
    localparam logic [1:0] BR_FWD   = 2'b10;
    localparam logic [1:0] BR_REV   = 2'b01;
    localparam logic [1:0] BR_COAST = 2'b00;

    function automatic int unsigned calc_period(input int unsigned clk_hz,
                                                input int unsigned pwm_hz);
        return clk_hz / pwm_hz;
    endfunction

endpackage

// File: rtl/motor_ramp_ch.sv
// One bridge channel: target registers, direction-reversal FSM, duty slew,
// coast dead-time and the period-latched PWM compare.
module motor_ramp_ch
    import motor_pkg::*;
#(
    parameter int unsigned DUTY_W    = 10,
    parameter int unsigned P_CLKS    = 4000,
    parameter int unsigned CNT_W     = 12,
    parameter int unsigned RAMP_STEP = 16,
    parameter int unsigned DEAD_CYC  = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              wrap,
    input  logic              tick,
    input  logic              estop,
    input  logic              cmd_load,
    input  logic [DUTY_W-1:0] tgt_duty_in,
    input  logic              tgt_dir_in,
    output logic              pwm,
    output logic [1:0]        bridge,
    output logic [DUTY_W-1:0] cur_duty,
    output logic              busy
);

    localparam int unsigned        DEAD_W    = $clog2(DEAD_CYC + 1);
    localparam logic [DEAD_W-1:0]  DEAD_LAST = DEAD_W'(DEAD_CYC - 1);
    localparam logic [DUTY_W-1:0]  STEP_V    = DUTY_W'(RAMP_STEP);

    ch_state_t          state_q, state_d;
    logic [DUTY_W-1:0]  tgt_duty_q, tgt_duty_d;
    logic               tgt_dir_q, tgt_dir_d;
    logic               act_dir_q, act_dir_d;
    logic [DUTY_W-1:0]  cur_q, cur_d;
    logic [DEAD_W-1:0]  dead_q, dead_d;
    logic [CNT_W-1:0]   thr_q, thr_d;
    logic               pwm_q, pwm_d;
    logic [DUTY_W-1:0]  goal;
    logic [DUTY_W-1:0]  ramp_val;
    logic               driving;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tgt_duty_q <= '0;
            tgt_dir_q  <= 1'b1;
            act_dir_q  <= 1'b1;
            cur_q      <= '0;
            dead_q     <= '0;
            thr_q      <= '0;
            pwm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_duty_q <= tgt_duty_d;
            tgt_dir_q  <= tgt_dir_d;
            act_dir_q  <= act_dir_d;
            cur_q      <= cur_d;
            dead_q     <= dead_d;
            thr_q      <= thr_d;
            pwm_q      <= pwm_d;
        end
    end

    assign driving = (state_q == ST_DRIVE) || (state_q == ST_DECEL);

    // Slew toward goal by at most one step, landing exactly on goal
    always_comb begin
        ramp_val = goal;
        if (goal > cur_q) begin
            if ((goal - cur_q) > STEP_V) ramp_val = cur_q + STEP_V;
        end else if ((cur_q - goal) > STEP_V) begin
            ramp_val = cur_q - STEP_V;
        end
    end

    always_comb begin
        tgt_duty_d = tgt_duty_q;
        tgt_dir_d  = tgt_dir_q;
        state_d    = state_q;
        act_dir_d  = act_dir_q;
        cur_d      = cur_q;
        dead_d     = '0;
        thr_d      = thr_q;
        goal       = tgt_duty_q;

        if (cmd_load) begin
            tgt_duty_d = tgt_duty_in;
            tgt_dir_d  = tgt_dir_in;
        end

        unique case (state_q)
            ST_IDLE: begin
                cur_d = '0;
                if (tgt_duty_q != '0) begin
                    state_d   = ST_DRIVE;
                    act_dir_d = tgt_dir_q;
                end
            end
            ST_DRIVE: begin
                // A pending reversal must never ramp further away from zero
                if (tgt_dir_q != act_dir_q) begin
                    goal    = '0;
                    state_d = (cur_q != '0) ? ST_DECEL : ST_DEAD;
                end else if (tgt_duty_q == '0 && cur_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECEL: begin
                goal = '0;
                if (tgt_dir_q == act_dir_q) begin
                    state_d = ST_DRIVE;
                end else if (cur_q == '0) begin
                    state_d = ST_DEAD;
                end
            end
            ST_DEAD: begin
                cur_d = '0;
                if (dead_q == DEAD_LAST) begin
                    act_dir_d = tgt_dir_q;
                    state_d   = (tgt_duty_q == '0) ? ST_IDLE : ST_DRIVE;
                end else begin
                    dead_d = dead_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tick && driving) cur_d = ramp_val;

        if (wrap) thr_d = CNT_W'((32'(P_CLKS) * 32'(cur_q)) >> DUTY_W);

        pwm_d = driving && (cnt < thr_q);

        // Emergency stop overrides everything except the target registers
        if (estop) begin
            state_d = ST_IDLE;
            cur_d   = '0;
            dead_d  = '0;
            thr_d   = '0;
            pwm_d   = 1'b0;
        end
    end

    always_comb begin
        bridge = BR_COAST;
        if (driving) bridge = act_dir_q ? BR_FWD : BR_REV;
    end

    assign pwm      = pwm_q;
    assign cur_duty = cur_q;
    assign busy     = (cur_q != tgt_duty_q) || (state_q == ST_DECEL) || (state_q == ST_DEAD);

endmodule

// File: rtl/motor_ramp_drive.sv
// N-channel soft-start H-bridge driver: shared PWM period counter and ramp
// prescaler feeding one motor_ramp_ch per bridge.
module motor_ramp_drive
    import motor_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned DUTY_W    = 10,
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned PWM_HZ    = 25000,
    parameter int unsigned RAMP_DIV  = 100000,
    parameter int unsigned RAMP_STEP = 16,
    parameter int unsigned DEAD_CYC  = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_load,
    input  logic [N_CH*DUTY_W-1:0]   tgt_duty,
    input  logic [N_CH-1:0]          tgt_dir,
    input  logic                     estop,
    output logic [N_CH-1:0]          pwm,
    output logic [2*N_CH-1:0]        bridge_in,
    output logic [N_CH*DUTY_W-1:0]   cur_duty,
    output logic [N_CH-1:0]          busy
);

    localparam int unsigned       P       = calc_period(CLK_HZ, PWM_HZ);
    localparam int unsigned       CNT_W   = $clog2(P + 1);
    localparam int unsigned       PRE_W   = $clog2(RAMP_DIV + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(P - 1);
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             wrap;
    logic             tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            pre_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            pre_q <= pre_d;
        end
    end

    assign wrap = (cnt_q == CNT_MAX);
    assign tick = (pre_q == PRE_MAX);

    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            motor_ramp_ch #(
                .DUTY_W    (DUTY_W),
                .P_CLKS    (P),
                .CNT_W     (CNT_W),
                .RAMP_STEP (RAMP_STEP),
                .DEAD_CYC  (DEAD_CYC)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .cnt         (cnt_q),
                .wrap        (wrap),
                .tick        (tick),
                .estop       (estop),
                .cmd_load    (cmd_load),
                .tgt_duty_in (tgt_duty[gi*DUTY_W +: DUTY_W]),
                .tgt_dir_in  (tgt_dir[gi]),
                .pwm         (pwm[gi]),
                .bridge      (bridge_in[2*gi +: 2]),
                .cur_duty    (cur_duty[gi*DUTY_W +: DUTY_W]),
                .busy        (busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_motor_ramp_drive.sv
// Directed bench for motor_ramp_drive at P=100, RAMP_DIV=4, RAMP_STEP=16, DEAD_CYC=8.
module tb_motor_ramp_drive;

    localparam int N_CH   = 2;
    localparam int DUTY_W = 10;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cmd_load;
    logic [N_CH*DUTY_W-1:0] tgt_duty;
    logic [N_CH-1:0]        tgt_dir;
    logic                   estop;
    logic [N_CH-1:0]        pwm;
    logic [2*N_CH-1:0]      bridge_in;
    logic [N_CH*DUTY_W-1:0] cur_duty;
    logic [N_CH-1:0]        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0] d0;
        logic       r0;
        logic [9:0] d1;
        logic       r1;
        int         hi0;
        int         hi1;
        logic [3:0] br;
    } vec_t;

    vec_t vecs[5];

    motor_ramp_drive #(
        .N_CH(N_CH), .DUTY_W(DUTY_W), .CLK_HZ(1000), .PWM_HZ(10),
        .RAMP_DIV(4), .RAMP_STEP(16), .DEAD_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .cmd_load(cmd_load), .tgt_duty(tgt_duty),
        .tgt_dir(tgt_dir), .estop(estop), .pwm(pwm), .bridge_in(bridge_in),
        .cur_duty(cur_duty), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] cur(input int k);
        return cur_duty[k*DUTY_W +: DUTY_W];
    endfunction

    task automatic load(input logic [9:0] d0, input logic r0, input logic [9:0] d1, input logic r1);
        tgt_duty = {d1, d0};
        tgt_dir  = {r1, r0};
        cmd_load = 1'b1;
        step();
        cmd_load = 1'b0;
    endtask

    task automatic wait_settled(input string name, input int bound);
        int n = 0;
        step();
        step();
        while (busy !== '0 && n < bound) begin
            step();
            n++;
        end
        if (busy !== '0) chk({name, "_settle_timeout"}, busy, 0);
    endtask

    task automatic wait_change(input string name, input int k, input int bound,
                               output logic [9:0] val, output int cyc);
        logic [9:0] prev = cur(k);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (cur(k) == prev && cyc < bound);
        val = cur(k);
        if (val == prev) chk({name, "_change_timeout"}, val, 32'(prev) + 1);
    endtask

    task automatic count_high(output int h0, output int h1);
        h0 = 0;
        h1 = 0;
        for (int j = 0; j < 100; j++) begin
            step();
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
        end
    endtask

    initial begin
        logic [9:0] v;
        int         c, h0, h1, n, fall0, fall1, chg0, chg1;
        logic       pwm_seen, prev0, prev1;
        logic [9:0] p0, p1;
        logic [9:0] exp_dn[4];

        vecs[0] = '{d0: 10'd512,  r0: 1'b1, d1: 10'd0,    r1: 1'b1, hi0: 50, hi1: 0,  br: 4'b0010};
        vecs[1] = '{d0: 10'd200,  r0: 1'b0, d1: 10'd1023, r1: 1'b1, hi0: 19, hi1: 99, br: 4'b1001};
        vecs[2] = '{d0: 10'd70,   r0: 1'b1, d1: 10'd64,   r1: 1'b0, hi0: 6,  hi1: 6,  br: 4'b0110};
        vecs[3] = '{d0: 10'd1023, r0: 1'b1, d1: 10'd1023, r1: 1'b1, hi0: 99, hi1: 99, br: 4'b1010};
        vecs[4] = '{d0: 10'd0,    r0: 1'b1, d1: 10'd0,    r1: 1'b1, hi0: 0,  hi1: 0,  br: 4'b0000};

        // Reset state
        rst = 1'b1; estop = 1'b1; cmd_load = 1'b0; tgt_duty = '0; tgt_dir = '1;
        repeat (3) step();
        chk("rst_pwm", pwm, 0);
        chk("rst_bridge", bridge_in, 0);
        chk("rst_cur", cur_duty, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // 1. Static duty ramp from estop release
        load(10'd512, 1'b1, 10'd0, 1'b1);
        repeat (10) step();
        chk("t1_estop_cur", cur(0), 0);
        chk("t1_estop_bridge", bridge_in, 0);
        estop = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            wait_change("t1", 0, 20, v, c);
            chk($sformatf("t1_step%0d", i), v, 16 * i);
            if (i > 1) chk($sformatf("t1_gap%0d", i), c, 4);
            if (i == 31) chk("t1_busy_before", busy[0], 1);
        end
        chk("t1_busy_drop", busy[0], 0);
        chk("t1_bridge", bridge_in, 4'b0010);
        repeat (200) step();
        count_high(h0, h1);
        chk("t1_high50", h0, 50);

        // 2. Retarget mid-ramp, then a short final step
        load(10'd0, 1'b1, 10'd0, 1'b1);
        wait_settled("t2_zero", 400);
        repeat (10) step();
        load(10'd512, 1'b1, 10'd0, 1'b1);
        for (int i = 1; i <= 8; i++) wait_change("t2_up", 0, 20, v, c);
        chk("t2_at128", v, 128);
        load(10'd64, 1'b1, 10'd0, 1'b1);
        exp_dn = '{10'd112, 10'd96, 10'd80, 10'd64};
        for (int i = 0; i < 4; i++) begin
            wait_change("t2_dn", 0, 20, v, c);
            chk($sformatf("t2_dn%0d", i), v, exp_dn[i]);
        end
        repeat (20) step();
        chk("t2_no_overshoot", cur(0), 64);
        load(10'd70, 1'b1, 10'd0, 1'b1);
        wait_change("t2_small", 0, 20, v, c);
        chk("t2_small_step", v, 70);
        repeat (20) step();
        chk("t2_hold70", cur(0), 70);
        chk("t2_busy", busy[0], 0);

        // 3. Direction reversal: decel, dead-time, reverse ramp
        load(10'd256, 1'b1, 10'd0, 1'b1);
        wait_settled("t3_fwd", 400);
        load(10'd256, 1'b0, 10'd0, 1'b1);
        n = 0;
        do begin
            wait_change("t3_decel", 0, 20, v, c);
            n++;
        end while (v != 0 && n < 20);
        chk("t3_decel_ticks", n, 16);
        chk("t3_decel_bridge", bridge_in[1:0], 2'b10);
        step();
        n = 0;
        pwm_seen = 1'b0;
        while (bridge_in[1:0] == 2'b00 && n < 20) begin
            pwm_seen |= pwm[0];
            n++;
            step();
        end
        chk("t3_dead_len", n, 8);
        chk("t3_dead_pwm", pwm_seen, 0);
        chk("t3_rev_bridge", bridge_in[1:0], 2'b01);
        wait_settled("t3_rev", 400);
        chk("t3_rev_cur", cur(0), 256);

        // 4. estop with a target load during the stop
        load(10'd300, 1'b1, 10'd0, 1'b1);
        wait_settled("t4_run", 600);
        chk("t4_cur300", cur(0), 300);
        n = 0;
        while (pwm[0] !== 1'b1 && n < 200) begin step(); n++; end
        chk("t4_pwm_high_before", pwm[0], 1);
        estop = 1'b1;
        step();
        chk("t4_pwm_off", pwm[0], 0);
        chk("t4_bridge_coast", bridge_in, 0);
        chk("t4_cur_zero", cur(0), 0);
        load(10'd160, 1'b1, 10'd0, 1'b1);
        repeat (5) step();
        chk("t4_hold_zero", cur(0), 0);
        chk("t4_busy_retained", busy[0], 1);
        estop = 1'b0;
        wait_change("t4_restart", 0, 20, v, c);
        chk("t4_first_step", v, 16);
        wait_settled("t4_reach", 400);
        chk("t4_cur160", cur(0), 160);

        // 5. Mid-period duty change waits for the period wrap
        load(10'd512, 1'b1, 10'd0, 1'b1);
        wait_settled("t5_run", 400);
        repeat (150) step();
        n = 0;
        prev0 = pwm[0];
        step();
        while (!(pwm[0] == 1'b1 && prev0 == 1'b0) && n < 200) begin
            prev0 = pwm[0];
            step();
            n++;
        end
        h0 = int'(pwm[0]);
        for (int j = 1; j < 100; j++) begin
            if (j == 40) begin
                tgt_duty = {10'd0, 10'd1023};
                cmd_load = 1'b1;
            end
            step();
            cmd_load = 1'b0;
            h0 += int'(pwm[0]);
        end
        chk("t5_period_high", h0, 50);
        chk("t5_end_low", pwm[0], 0);
        step();
        chk("t5_wrap_rise", pwm[0], 1);
        wait_settled("t5_max", 400);
        repeat (150) step();
        count_high(h0, h1);
        chk("t5_high99", h0, 99);

        // Table-driven steady-state vectors
        foreach (vecs[i]) begin
            load(vecs[i].d0, vecs[i].r0, vecs[i].d1, vecs[i].r1);
            wait_settled($sformatf("vec%0d", i), 800);
            repeat (250) step();
            count_high(h0, h1);
            chk($sformatf("vec%0d_hi0", i), h0, vecs[i].hi0);
            chk($sformatf("vec%0d_hi1", i), h1, vecs[i].hi1);
            chk($sformatf("vec%0d_bridge", i), bridge_in, vecs[i].br);
            chk($sformatf("vec%0d_cur0", i), cur(0), vecs[i].d0);
            chk($sformatf("vec%0d_cur1", i), cur(1), vecs[i].d1);
        end

        // 6. Two channels from IDLE, independent ramps
        load(10'd1023, 1'b1, 10'd200, 1'b0);
        chg0 = 0; chg1 = 0; fall0 = -1; fall1 = -1;
        p0 = cur(0); p1 = cur(1);
        n = 0;
        while ((fall0 < 0 || fall1 < 0) && n < 600) begin
            step();
            n++;
            if (cur(0) != p0) chg0++;
            if (cur(1) != p1) chg1++;
            p0 = cur(0); p1 = cur(1);
            if (busy[0] == 1'b0 && fall0 < 0) fall0 = chg0;
            if (busy[1] == 1'b0 && fall1 < 0) fall1 = chg1;
        end
        chk("t6_ch0_ticks", fall0, 64);
        chk("t6_ch1_ticks", fall1, 13);
        repeat (250) step();
        chk("t6_bridge", bridge_in, 4'b0110);
        n = 0;
        prev0 = pwm[0];
        prev1 = pwm[1];
        step();
        while (!(pwm[1] == 1'b1 && prev1 == 1'b0) && n < 200) begin
            prev0 = pwm[0];
            prev1 = pwm[1];
            step();
            n++;
        end
        chk("t6_ch1_rise", {prev1, pwm[1]}, 2'b01);
        chk("t6_ch0_rise", {prev0, pwm[0]}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
